cpm_topk_serializer: RTL and testbench

//  Reader side of the CPM top-K interface. Captures the parallel top-K result (SORT_DW entries of

---
 rtl/cpm_topk_serializer_if.sv | 34 +++
 rtl/cpm_topk_serializer.sv | 143 ++++++++++++++
 tb/tb_cpm_topk_serializer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpm_topk_serializer_if.sv
// Bus bundle between the top-K sorter, the serializer and the downstream CPM result path.
// The slave modport is the serializer's view; master is the surrounding environment.
interface cpm_topk_serializer_if #(
    parameter int unsigned DATA_DW = 8,
    parameter int unsigned INFO_DW = 8,
    parameter int unsigned SORT_DW = 32,
    parameter int unsigned SORT_AW = $clog2(SORT_DW)
);
    logic                       clear;
    logic                       TOPK_DAT_VLD;
    logic                       TOPK_DAT_RDY;
    logic [SORT_DW*DATA_DW-1:0] TOPK_DAT_DAT;
    logic [SORT_DW*INFO_DW-1:0] TOPK_DAT_INF;
    logic [SORT_AW:0]           CFG_NUM;
    logic                       OUT_DAT_VLD;
    logic                       OUT_DAT_RDY;
    logic                       OUT_DAT_LST;
    logic [DATA_DW-1:0]         OUT_DAT_DAT;
    logic [INFO_DW-1:0]         OUT_DAT_INF;
    logic [SORT_AW-1:0]         OUT_DAT_IDX;
    logic                       BUSY;

    modport slave (
        input  clear, TOPK_DAT_VLD, TOPK_DAT_DAT, TOPK_DAT_INF, CFG_NUM, OUT_DAT_RDY,
        output TOPK_DAT_RDY, OUT_DAT_VLD, OUT_DAT_LST, OUT_DAT_DAT, OUT_DAT_INF,
               OUT_DAT_IDX, BUSY
    );

    modport master (
        output clear, TOPK_DAT_VLD, TOPK_DAT_DAT, TOPK_DAT_INF, CFG_NUM, OUT_DAT_RDY,
        input  TOPK_DAT_RDY, OUT_DAT_VLD, OUT_DAT_LST, OUT_DAT_DAT, OUT_DAT_INF,
               OUT_DAT_IDX, BUSY
    );
endinterface

// File: rtl/cpm_topk_serializer.sv
// Captures a parallel top-K result into a shadow buffer and streams the first CFG_NUM
// entries out one per beat; every output is a register, so there is no input-to-output path.
module cpm_topk_serializer #(
    parameter int unsigned DATA_DW = 8,
    parameter int unsigned INFO_DW = 8,
    parameter int unsigned SORT_DW = 32,
    parameter int unsigned SORT_AW = $clog2(SORT_DW)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpm_topk_serializer_if.slave  bus
);
    localparam int unsigned NUM_W = SORT_AW + 1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t             state;
    logic               armed;
    logic [SORT_AW-1:0] cnt;
    logic [NUM_W-1:0]   num;
    logic [DATA_DW-1:0] sh_dat [SORT_DW];
    logic [INFO_DW-1:0] sh_inf [SORT_DW];

    logic               rdy_q;
    logic               vld_q;
    logic               lst_q;
    logic [DATA_DW-1:0] dat_q;
    logic [INFO_DW-1:0] inf_q;
    logic [SORT_AW-1:0] idx_q;
    logic               busy_q;

    logic               cap_c;
    logic               hs_c;
    logic               armed_nxt_c;
    logic [NUM_W-1:0]   num_sel_c;
    logic [SORT_AW-1:0] cnt_nxt_c;
    logic               lst_nxt_c;

    assign bus.TOPK_DAT_RDY = rdy_q;
    assign bus.OUT_DAT_VLD  = vld_q;
    assign bus.OUT_DAT_LST  = lst_q;
    assign bus.OUT_DAT_DAT  = dat_q;
    assign bus.OUT_DAT_INF  = inf_q;
    assign bus.OUT_DAT_IDX  = idx_q;
    assign bus.BUSY         = busy_q;

    // Handshakes, frame length clamp and the re-arm rule for the level-sticky valid.
    always_comb begin
        cap_c       = bus.TOPK_DAT_VLD && rdy_q;
        hs_c        = vld_q && bus.OUT_DAT_RDY;
        armed_nxt_c = armed;
        if (cap_c) begin
            armed_nxt_c = 1'b0;
        end else if (!bus.TOPK_DAT_VLD) begin
            armed_nxt_c = 1'b1;
        end
        num_sel_c = bus.CFG_NUM;
        if (bus.CFG_NUM == NUM_W'(0) || bus.CFG_NUM > NUM_W'(SORT_DW)) begin
            num_sel_c = NUM_W'(SORT_DW);
        end
        cnt_nxt_c = cnt + SORT_AW'(1);
        lst_nxt_c = (NUM_W'(cnt_nxt_c) + NUM_W'(1)) == num;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            armed  <= 1'b0;
            cnt    <= '0;
            num    <= '0;
            rdy_q  <= 1'b0;
            vld_q  <= 1'b0;
            lst_q  <= 1'b0;
            dat_q  <= '0;
            inf_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            for (int unsigned i = 0; i < SORT_DW; i++) begin
                sh_dat[i] <= '0;
                sh_inf[i] <= '0;
            end
        end else if (bus.clear) begin
            state  <= IDLE;
            armed  <= 1'b0;
            cnt    <= '0;
            rdy_q  <= 1'b0;
            vld_q  <= 1'b0;
            lst_q  <= 1'b0;
            dat_q  <= '0;
            inf_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            for (int unsigned i = 0; i < SORT_DW; i++) begin
                sh_dat[i] <= '0;
                sh_inf[i] <= '0;
            end
        end else begin
            armed <= armed_nxt_c;
            case (state)
                IDLE: begin
                    rdy_q <= armed_nxt_c;
                    if (cap_c) begin
                        // First beat is presented straight from the capture, no bubble.
                        state  <= SEND;
                        num    <= num_sel_c;
                        cnt    <= '0;
                        rdy_q  <= 1'b0;
                        vld_q  <= 1'b1;
                        lst_q  <= (num_sel_c == NUM_W'(1));
                        dat_q  <= bus.TOPK_DAT_DAT[DATA_DW-1:0];
                        inf_q  <= bus.TOPK_DAT_INF[INFO_DW-1:0];
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        for (int unsigned i = 0; i < SORT_DW; i++) begin
                            sh_dat[i] <= bus.TOPK_DAT_DAT[i*DATA_DW +: DATA_DW];
                            sh_inf[i] <= bus.TOPK_DAT_INF[i*INFO_DW +: INFO_DW];
                        end
                    end
                end
                SEND: begin
                    if (hs_c && lst_q) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        rdy_q  <= armed_nxt_c;
                        vld_q  <= 1'b0;
                        lst_q  <= 1'b0;
                        dat_q  <= '0;
                        inf_q  <= '0;
                        idx_q  <= '0;
                        busy_q <= 1'b0;
                    end else if (hs_c) begin
                        cnt   <= cnt_nxt_c;
                        lst_q <= lst_nxt_c;
                        dat_q <= sh_dat[cnt_nxt_c];
                        inf_q <= sh_inf[cnt_nxt_c];
                        idx_q <= cnt_nxt_c;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpm_topk_serializer.sv
// Directed bench for the top-K serializer: framing, backpressure, sticky-valid re-arm,
// frame-length clamping, soft clear and asynchronous reset mid-frame.
module tb_cpm_topk_serializer;
    localparam int unsigned DATA_DW = 8;
    localparam int unsigned INFO_DW = 8;
    localparam int unsigned SORT_DW = 32;
    localparam int unsigned SORT_AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    cpm_topk_serializer_if #(
        .DATA_DW(DATA_DW), .INFO_DW(INFO_DW), .SORT_DW(SORT_DW), .SORT_AW(SORT_AW)
    ) bus ();

    cpm_topk_serializer #(
        .DATA_DW(DATA_DW), .INFO_DW(INFO_DW), .SORT_DW(SORT_DW), .SORT_AW(SORT_AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entries(input int base);
        for (int i = 0; i < int'(SORT_DW); i++) begin
            bus.TOPK_DAT_DAT[i*DATA_DW +: DATA_DW] = 8'(base - i);
            bus.TOPK_DAT_INF[i*INFO_DW +: INFO_DW] = 8'(i);
        end
    endtask

    // Drop valid for one cycle to re-arm, then raise it; returns just after the capture edge.
    task automatic start_frame(input int cfg);
        bus.CFG_NUM      = 6'(cfg);
        bus.TOPK_DAT_VLD = 1'b0;
        step();
        bus.TOPK_DAT_VLD = 1'b1;
        step();
    endtask

    // {vld, lst, idx, dat, inf} of the beat currently presented.
    function automatic logic [22:0] beat_got();
        return {bus.OUT_DAT_VLD, bus.OUT_DAT_LST, bus.OUT_DAT_IDX, bus.OUT_DAT_DAT, bus.OUT_DAT_INF};
    endfunction

    function automatic logic [22:0] beat_exp(input int base, input int b, input int n);
        return {1'b1, 1'(b == n - 1), 5'(b), 8'(base - b), 8'(b)};
    endfunction

    task automatic test_reset();
        logic [22:0] got;
        bus.clear        = 1'b0;
        bus.TOPK_DAT_VLD = 1'b1;
        bus.CFG_NUM      = '0;
        bus.OUT_DAT_RDY  = 1'b1;
        load_entries(100);
        #12;
        got = beat_got();
        vec_cnt++;
        if (got !== 23'h0 || bus.TOPK_DAT_RDY !== 1'b0 || bus.BUSY !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got beat=%h rdy=%b busy=%b, need all 0",
                     got, bus.TOPK_DAT_RDY, bus.BUSY);
        end
        rst_n = 1'b1;
        step();
        step();
        vec_cnt++;
        if (bus.TOPK_DAT_RDY !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_sticky_vld: got rdy=%b, need 0", bus.TOPK_DAT_RDY);
        end
        bus.TOPK_DAT_VLD = 1'b0;
        step();
        vec_cnt++;
        if (bus.TOPK_DAT_RDY !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_arm: got rdy=%b, need 1", bus.TOPK_DAT_RDY);
        end
    endtask

    task automatic test_basic_frame();
        logic [22:0] got;
        bus.OUT_DAT_RDY = 1'b1;
        load_entries(100);
        start_frame(4);
        load_entries(50);
        for (int b = 0; b < 4; b++) begin
            got = beat_got();
            vec_cnt++;
            if (got !== beat_exp(100, b, 4) || bus.BUSY !== 1'b1) begin
                err_cnt++;
                $display("FAIL basic_beat%0d: got %h busy=%b, need %h busy=1",
                         b, got, bus.BUSY, beat_exp(100, b, 4));
            end
            step();
        end
        vec_cnt++;
        if (bus.BUSY !== 1'b0 || bus.OUT_DAT_VLD !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_end: got busy=%b vld=%b, need 0/0", bus.BUSY, bus.OUT_DAT_VLD);
        end
    endtask

    task automatic test_sticky_vld();
        logic [22:0] got;
        for (int k = 0; k < 5; k++) begin
            vec_cnt++;
            if (bus.OUT_DAT_VLD !== 1'b0 || bus.TOPK_DAT_RDY !== 1'b0) begin
                err_cnt++;
                $display("FAIL sticky_no_frame%0d: got vld=%b rdy=%b, need 0/0",
                         k, bus.OUT_DAT_VLD, bus.TOPK_DAT_RDY);
            end
            step();
        end
        load_entries(100);
        start_frame(4);
        for (int b = 0; b < 4; b++) begin
            got = beat_got();
            vec_cnt++;
            if (got !== beat_exp(100, b, 4)) begin
                err_cnt++;
                $display("FAIL sticky_rearm_beat%0d: got %h, need %h", b, got, beat_exp(100, b, 4));
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [22:0] got;
        int nb = 0;
        bit done = 1'b0;
        load_entries(100);
        start_frame(4);
        for (int k = 0; k < 20 && !done; k++) begin
            bus.OUT_DAT_RDY = (k % 2 == 0);
            if (bus.OUT_DAT_VLD) begin
                got = beat_got();
                vec_cnt++;
                if (got !== beat_exp(100, nb, 4)) begin
                    err_cnt++;
                    $display("FAIL bp_cycle%0d: got %h, need %h", k, got, beat_exp(100, nb, 4));
                end
                if (bus.OUT_DAT_RDY) begin
                    done = (nb == 3);
                    nb++;
                end
            end
            step();
        end
        bus.OUT_DAT_RDY = 1'b1;
        vec_cnt++;
        if (nb != 4 || bus.OUT_DAT_VLD !== 1'b0 || bus.BUSY !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_count: got beats=%0d vld=%b busy=%b, need 4/0/0",
                     nb, bus.OUT_DAT_VLD, bus.BUSY);
        end
    endtask

    task automatic test_cfg_limits();
        logic [22:0] got;
        int cfgs [2] = '{0, 33};
        load_entries(100);
        for (int c = 0; c < 2; c++) begin
            start_frame(cfgs[c]);
            for (int b = 0; b < 32; b++) begin
                got = beat_got();
                vec_cnt++;
                if (got !== beat_exp(100, b, 32)) begin
                    err_cnt++;
                    $display("FAIL cfg%0d_beat%0d: got %h, need %h",
                             cfgs[c], b, got, beat_exp(100, b, 32));
                end
                step();
            end
            vec_cnt++;
            if (bus.OUT_DAT_VLD !== 1'b0 || bus.BUSY !== 1'b0) begin
                err_cnt++;
                $display("FAIL cfg%0d_end: got vld=%b busy=%b, need 0/0",
                         cfgs[c], bus.OUT_DAT_VLD, bus.BUSY);
            end
        end
    endtask

    task automatic test_clear();
        logic [22:0] got;
        load_entries(100);
        start_frame(8);
        step();
        step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        vec_cnt++;
        if (bus.OUT_DAT_VLD !== 1'b0 || bus.BUSY !== 1'b0 || bus.TOPK_DAT_RDY !== 1'b0) begin
            err_cnt++;
            $display("FAIL clear_abort: got vld=%b busy=%b rdy=%b, need 0/0/0",
                     bus.OUT_DAT_VLD, bus.BUSY, bus.TOPK_DAT_RDY);
        end
        load_entries(200);
        start_frame(8);
        for (int b = 0; b < 8; b++) begin
            got = beat_got();
            vec_cnt++;
            if (got !== beat_exp(200, b, 8)) begin
                err_cnt++;
                $display("FAIL clear_new_beat%0d: got %h, need %h", b, got, beat_exp(200, b, 8));
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        logic [22:0] got;
        load_entries(100);
        start_frame(8);
        for (int b = 0; b < 5; b++) step();
        got = beat_got();
        vec_cnt++;
        if (got !== beat_exp(100, 5, 8)) begin
            err_cnt++;
            $display("FAIL areset_pre: got %h, need %h", got, beat_exp(100, 5, 8));
        end
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (bus.OUT_DAT_VLD !== 1'b0 || bus.TOPK_DAT_RDY !== 1'b0 || bus.BUSY !== 1'b0) begin
            err_cnt++;
            $display("FAIL areset_now: got vld=%b rdy=%b busy=%b, need 0/0/0",
                     bus.OUT_DAT_VLD, bus.TOPK_DAT_RDY, bus.BUSY);
        end
        bus.TOPK_DAT_VLD = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        vec_cnt++;
        if (bus.TOPK_DAT_RDY !== 1'b1) begin
            err_cnt++;
            $display("FAIL areset_rearm: got rdy=%b, need 1", bus.TOPK_DAT_RDY);
        end
        load_entries(150);
        start_frame(2);
        for (int b = 0; b < 2; b++) begin
            got = beat_got();
            vec_cnt++;
            if (got !== beat_exp(150, b, 2)) begin
                err_cnt++;
                $display("FAIL areset_frame_beat%0d: got %h, need %h", b, got, beat_exp(150, b, 2));
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_sticky_vld();
        test_backpressure();
        test_cfg_limits();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
